multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control unit for the multicycle RV32I datapath; it is the producer of the 3-bit ALUControl code consumed by the ALU.
- A Moore main FSM sequences fetch/decode/execute/memory/writeback.
- An ALU decoder maps ALUOp/funct fields to the ALU encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

Parameters:
- none. All encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  Instr[6:0] from the instruction register.
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction/OldPC register enable.
- ResultSrc  output  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  A select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  output  2  B select: 00 WriteData, 01 ImmExt, 10 constant 4.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- RegWrite  output  1  register file write strobe.
- ALUControl  output  3  ALU operation code.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL. The state register is the only storage.
- Synchronous reset: state <= FETCH. While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced 0 combinationally. Other outputs follow FETCH decode.
- Reset mid-instruction abandons the instruction. The first cycle after reset deassertion is FETCH.
- State actions (unlisted outputs are 0/00; ALUOp 00 = add, 01 = sub, 10 = funct):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target computation). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH (illegal op is a 2-cycle no-op; no strobes fire)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- PCWrite = PCUpdate | (Branch & BranchCond), where BranchCond = Zero. This is the only Mealy output.
- ImmSrc is combinational from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- ALU decoder (combinational):
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, funct3=000 -> 001 if (op[5] & funct7b5), else 000.
  - ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
  - ALUOp 11 -> 000.
- Instruction latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN.
- Defined: in BEQ state, BranchCond = Zero when funct3=000 and ~Zero when funct3=001; other funct3 give BranchCond = 0.
- Undefined: BranchCond = Zero regardless of funct3, so bne behaves as beq.

Decomposition:
- Package multicycle_pkg holds:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUOp constants
  - ALU control codes (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101)
  - mux select constants
- One sub-module, alu_decoder (ALUOp, op5, funct3, funct7b5 -> ALUControl), instantiated once.

Test Plan:
- Reset held 3 cycles with op=0110011 -> all write strobes 0 throughout; after release, cycle 1 shows IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000.
- lw (op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 only in cycle 5; back to FETCH in cycle 6.
- sub (op=0110011, funct3=000, funct7b5=1) -> EXECR shows ALUControl=001. Same instruction with funct7b5=0 -> 000. addi with funct7b5=1 -> 000.
- beq with Zero=1 -> PCWrite=1 in BEQ cycle, ALUControl=001. With Zero=0 -> PCWrite=0. Both return to FETCH.
- jal (op=1101111) -> JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11; next cycle ALUWB with RegWrite=1.
- op=1111111 -> FETCH, DECODE, FETCH with no MemWrite/RegWrite.
- With MULTICYCLE_CTRL_BNE_EN defined, funct3=001 and Zero=0 -> PCWrite=1 in the BEQ-state cycle.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALUOp and ALU control codes, and datapath mux selects.
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp and instruction funct fields to the 3-bit ALU operation code.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          // op5 separates R-type sub from addi, whose bit 30 is immediate data
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: Moore main FSM plus ALU decoder.
// Define MULTICYCLE_CTRL_BNE_EN to make funct3=001 branch on ~Zero (bne).
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl
);

  state_e     state_q, state_d, dec_state;
  logic [1:0] aluop;
  logic       pcupdate, branch, branchcond;
  logic       memwrite_raw, irwrite_raw, regwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    // Under reset the outputs decode as FETCH whatever the register holds
    dec_state    = reset ? StFetch : state_q;
    state_d      = StFetch;
    aluop        = ALUOP_ADD;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    AdrSrc       = ADR_PC;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_WD;
    unique case (dec_state)
      StFetch: begin
        irwrite_raw = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        pcupdate    = 1'b1;
        state_d     = StDecode;
      end
      StDecode: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecR;
          OP_I:         state_d = StExecI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc  = ADR_ALUOUT;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc    = RES_DATA;
        regwrite_raw = 1'b1;
        state_d      = StFetch;
      end
      StMemWrite: begin
        AdrSrc       = ADR_ALUOUT;
        memwrite_raw = 1'b1;
        state_d      = StFetch;
      end
      StExecR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_WD;
        aluop   = ALUOP_FUNCT;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = StAluWb;
      end
      StAluWb: begin
        regwrite_raw = 1'b1;
        state_d      = StFetch;
      end
      StJal: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcupdate = 1'b1;
        state_d  = StAluWb;
      end
      StBeq: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_WD;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  always_comb begin
    unique case (funct3)
      3'b000:  branchcond = Zero;
      3'b001:  branchcond = ~Zero;
      default: branchcond = 1'b0;
    endcase
  end
`else
  assign branchcond = Zero;
`endif

  assign PCWrite  = ~reset & (pcupdate | (branch & branchcond));
  assign MemWrite = ~reset & memwrite_raw;
  assign IRWrite  = ~reset & irwrite_raw;
  assign RegWrite = ~reset & regwrite_raw;

  always_comb begin
    unique case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset corner cases
// and random instruction streams checked against a per-cycle instruction model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  // Word layout: pcw adr mw irw res[2] srca[2] srcb[2] imm[2] rw alu[3]
  function automatic logic [15:0] dut_word();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
            RegWrite, ALUControl};
  endfunction

  function automatic int len_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011: return 4;
      7'b0110011: return 4;
      7'b0010011: return 4;
      7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
`ifdef MULTICYCLE_CTRL_BNE_EN
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    return 1'b0;
`else
    return z;
`endif
  endfunction

  // Expected outputs for cycle idx of an instruction (idx 0 = fetch cycle)
  function automatic logic [15:0] model(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic z, input int idx,
                                        input logic rst);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    res = 0; sa = 0; sb = 0; alu = 0;
    imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 :
          (o == 7'b1101111) ? 2'd3 : 2'd0;
    if (rst || idx == 0) begin
      irw = !rst; pcw = !rst; sb = 2; res = 2;
    end else if (idx == 1) begin
      sa = 1; sb = 1;
    end else begin
      case (o)
        7'b0000011: begin
          if (idx == 2) begin sa = 2; sb = 1; end
          if (idx == 3) adr = 1;
          if (idx == 4) begin res = 1; rw = 1; end
        end
        7'b0100011: begin
          if (idx == 2) begin sa = 2; sb = 1; end
          if (idx == 3) begin adr = 1; mw = 1; end
        end
        7'b0110011, 7'b0010011: begin
          if (idx == 2) begin
            sa = 2; sb = (o == 7'b0010011) ? 2'd1 : 2'd0; alu = funct_alu(o, f3, f7);
          end
          if (idx == 3) rw = 1;
        end
        7'b1101111: begin
          if (idx == 2) begin sa = 1; sb = 2; pcw = 1; end
          if (idx == 3) rw = 1;
        end
        7'b1100011: begin
          sa = 2; alu = 3'd1; pcw = taken(f3, z);
        end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, res, sa, sb, imm, rw, alu};
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Runs one instruction; zmode 0/1 fixes Zero, 2 randomises it per cycle
  task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int key,
                           output logic [15:0] kw);
    int n;
    n  = len_of(o);
    kw = '0;
    for (int i = 0; i < n; i++) begin
      op = o; funct3 = f3; funct7b5 = f7;
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      @(negedge clk);
      check($sformatf("%s cyc%0d", nm, i), dut_word(), model(o, f3, f7, Zero, i, 1'b0));
      if (i == key) kw = dut_word();
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         zero;
    int         key;
    logic       pcw;
    logic       rw;
    logic [2:0] alu;
  } tvec_t;

  tvec_t       tbl[$];
  logic [15:0] kw;
  logic [6:0]  ops[7];
  logic [6:0]  ro;
  logic        bne_pcw;

  initial begin
`ifdef MULTICYCLE_CTRL_BNE_EN
    bne_pcw = 1'b1;
`else
    bne_pcw = 1'b0;
`endif
    tbl.push_back('{"lw",      7'b0000011, 3'd2, 1'b0, 0, 4, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"sub",     7'b0110011, 3'd0, 1'b1, 0, 2, 1'b0, 1'b0, 3'b001});
    tbl.push_back('{"add",     7'b0110011, 3'd0, 1'b0, 0, 2, 1'b0, 1'b0, 3'b000});
    tbl.push_back('{"addi_f7", 7'b0010011, 3'd0, 1'b1, 0, 2, 1'b0, 1'b0, 3'b000});
    tbl.push_back('{"slti",    7'b0010011, 3'd2, 1'b0, 0, 2, 1'b0, 1'b0, 3'b101});
    tbl.push_back('{"or",      7'b0110011, 3'd6, 1'b0, 0, 2, 1'b0, 1'b0, 3'b011});
    tbl.push_back('{"andi",    7'b0010011, 3'd7, 1'b0, 0, 2, 1'b0, 1'b0, 3'b010});
    tbl.push_back('{"beq_z1",  7'b1100011, 3'd0, 1'b0, 1, 2, 1'b1, 1'b0, 3'b001});
    tbl.push_back('{"beq_z0",  7'b1100011, 3'd0, 1'b0, 0, 2, 1'b0, 1'b0, 3'b001});
    tbl.push_back('{"jal",     7'b1101111, 3'd0, 1'b0, 0, 2, 1'b1, 1'b0, 3'b000});
    tbl.push_back('{"jal_wb",  7'b1101111, 3'd0, 1'b0, 0, 3, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"sw",      7'b0100011, 3'd2, 1'b0, 0, 3, 1'b0, 1'b0, 3'b000});
    tbl.push_back('{"bne_z0",  7'b1100011, 3'd1, 1'b0, 0, 2, bne_pcw, 1'b0, 3'b001});
    tbl.push_back('{"illegal", 7'b1111111, 3'd0, 1'b0, 0, 1, 1'b0, 1'b0, 3'b000});

    // Reset held three cycles with an R-type op: no strobes, FETCH decode otherwise
    reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1; Zero = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset cyc%0d", i), dut_word(), model(op, funct3, funct7b5, Zero, 0, 1'b1));
      @(posedge clk); #1;
    end
    reset = 1'b0;

    foreach (tbl[t]) begin
      run_instr(tbl[t].name, tbl[t].op, tbl[t].f3, tbl[t].f7, tbl[t].zero, tbl[t].key, kw);
      check({tbl[t].name, " key"}, {11'd0, kw[15], kw[3], kw[2:0]},
            {11'd0, tbl[t].pcw, tbl[t].rw, tbl[t].alu});
    end

    // Reset during MEMADR of a lw abandons it; the next cycle after release is FETCH
    for (int i = 0; i < 2; i++) begin
      op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
      @(negedge clk);
      check($sformatf("lw_abort cyc%0d", i), dut_word(), model(op, funct3, 1'b0, 1'b0, i, 1'b0));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("lw_abort reset", dut_word(), model(op, funct3, 1'b0, 1'b0, 2, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("after_abort", 7'b0110011, 3'd7, 1'b0, 0, -1, kw);

    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
            7'b1111111};
    for (int r = 0; r < 80; r++) begin
      int sel;
      sel = $urandom_range(0, 7);
      ro  = (sel == 7) ? 7'($urandom) : ops[sel];
      run_instr($sformatf("rnd%0d", r), ro, 3'($urandom), 1'($urandom), 2, -1, kw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
